// File: rtl/ahb_lite_mem_slave_pkg.sv
// Shared AHB-Lite definitions for the memory slave: transfer/size encodings,
// response codes and the slave response FSM state type.
package ahb_lite_defs;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3,
    SIZE_4WORD = 3'd4,
    SIZE_8WORD = 3'd5,
    SIZE_16W   = 3'd6,
    SIZE_32W   = 3'd7
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } slave_state_t;

endpackage

// File: rtl/ahb_lite_byte_ram.sv
// Single-port word RAM with per-byte write enables and combinational read.
// Contents are deliberately not reset.
module ahb_lite_byte_ram #(
  parameter int DATAWIDTH = 32,
  parameter int MEM_DEPTH = 256,
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int NB = DATAWIDTH / 8
) (
  input  logic                 clk_i,
  input  logic [AW-1:0]        addr_i,
  input  logic                 we_i,
  input  logic [NB-1:0]        be_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  output logic [DATAWIDTH-1:0] rdata_o
);

  logic [DATAWIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave with configurable wait states and two-cycle ERROR response.
//   state  | meaning
//   S_IDLE | no stall; final data-phase cycle of an OKAY transfer when dphase_q=1
//   S_WAIT | OKAY transfer stalling, cnt_q counts elapsed wait cycles
//   S_ERR1 | first ERROR cycle (HREADYOUT=0, HRESP=1)
//   S_ERR2 | second ERROR cycle (HREADYOUT=1, HRESP=1), may accept a new transfer
module ahb_lite_mem_slave
  import ahb_lite_defs::*;
#(
  parameter int                   DATAWIDTH   = 32,
  parameter int                   ADDRWIDTH   = 32,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR   = '0,
  parameter int                   MEM_DEPTH   = 256,
  parameter int                   WAIT_STATES = 0,
  parameter bit                   READ_ONLY   = 1'b0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [1:0]           HTRANS,
  input  logic                 HREADY,
  input  logic [DATAWIDTH-1:0] HWDATA,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int NB     = DATAWIDTH / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRWIDTH:0] REGION_BYTES = (ADDRWIDTH+1)'(MEM_DEPTH * NB);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  slave_state_t           state_q;
  logic [2:0]             cnt_q;
  logic [AW-1:0]          addr_q;
  logic [LANE_W-1:0]      lane_q;
  logic [2:0]             size_q;
  logic                   write_q;
  logic                   dphase_q;
  logic                   hreadyout_q;
  logic                   hresp_q;

  logic [ADDRWIDTH-1:0]   offset;
  logic [LANE_W-1:0]      size_mask;
  logic                   in_range, size_err, misalign, ro_err, req_err, accept;
  logic [NB-1:0]          be;
  logic                   we;
  logic [DATAWIDTH-1:0]   ram_rdata;

  assign offset = HADDR - BASE_ADDR;

  always_comb begin
    size_mask = ~({LANE_W{1'b1}} << HSIZE);
    in_range  = (HADDR >= BASE_ADDR) && ({1'b0, offset} < REGION_BYTES);
    size_err  = HSIZE > 3'(LANE_W);
    misalign  = |(HADDR[LANE_W-1:0] & size_mask);
    ro_err    = HWRITE && READ_ONLY;
    req_err   = !in_range || size_err || misalign || ro_err;
  end

  // Address phases are only taken while this slave is not stalling the bus.
  assign accept = HSEL && HREADY && hreadyout_q &&
                  (htrans_t'(HTRANS) inside {TRANS_NONSEQ, TRANS_SEQ});

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      dphase_q    <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state_q)
        S_WAIT: begin
          cnt_q <= cnt_q + 3'd1;
          if (({1'b0, cnt_q} + 4'd1) == 4'(WAIT_STATES)) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          dphase_q    <= 1'b0;
          if (accept) begin
            cnt_q   <= '0;
            addr_q  <= offset[LANE_W +: AW];
            lane_q  <= HADDR[LANE_W-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (req_err) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else begin
              dphase_q <= 1'b1;
              if (!NO_WAIT) begin
                state_q     <= S_WAIT;
                hreadyout_q <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  // A lane belongs to the transfer when it sits in the same 2^size group as the address.
  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++) begin
      be[b] = ((LANE_W'(b)) >> size_q) == (lane_q >> size_q);
    end
  end

  assign we = dphase_q && write_q && hreadyout_q;

  ahb_lite_byte_ram #(
    .DATAWIDTH (DATAWIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk_i   (HCLK),
    .addr_i  (addr_q),
    .we_i    (we),
    .be_i    (be),
    .wdata_i (HWDATA),
    .rdata_o (ram_rdata)
  );

  // A read accepted on a write's completing edge sees the merged word: the RAM
  // commits on the same edge that registers the read address.
  assign HRDATA    = (dphase_q && !write_q && hreadyout_q) ? ram_rdata : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench: four slave instances (WS=0, WS=3, WS=5, read-only) on one
// shared master, checked against a byte-array memory model and fixed vectors.
module tb_ahb_lite_mem_slave;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    logic        lo_resp;
    logic        lo_nz;
    int          waits;
  } xres_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    bit          eresp;
    logic [31:0] erd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] hwdata = '0;
  logic [1:0]  cur = 2'd0;

  logic [31:0] rd_v   [4];
  logic        rdy_v  [4];
  logic        resp_v [4];
  logic [31:0] c_rdata;
  logic        c_rdy, c_resp;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mb [1024];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    ahb_lite_mem_slave #(
      .DATAWIDTH   (32),
      .ADDRWIDTH   (32),
      .BASE_ADDR   (32'h0),
      .MEM_DEPTH   (256),
      .WAIT_STATES ((k == 1) ? 3 : ((k == 2) ? 5 : 0)),
      .READ_ONLY   (k == 3)
    ) u_dut (
      .HCLK      (clk),
      .HRESET    (rst),
      .HSEL      (hsel && (cur == 2'(k))),
      .HADDR     (haddr),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HTRANS    (htrans),
      .HREADY    (rdy_v[k]),
      .HWDATA    (hwdata),
      .HRDATA    (rd_v[k]),
      .HREADYOUT (rdy_v[k]),
      .HRESP     (resp_v[k])
    );
  end

  assign c_rdata = rd_v[cur];
  assign c_rdy   = rdy_v[cur];
  assign c_resp  = resp_v[cur];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    for (int k = 0; k < (1 << s); k++) begin
      mb[(a + k) % 1024] = wd[8 * ((a % 4) + k) +: 8];
    end
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = (a - (a % 4)) % 1024;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] s, input bit wr, input bit ro);
    return (a >= 32'd1024) || (s > 3'd2) || ((a % (32'd1 << s)) != 0) || (wr && ro);
  endfunction

  // One non-pipelined transfer; entered and left just after a rising edge.
  task automatic xfer(input int inst, input bit wr, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd, output xres_t r);
    cur = 2'(inst); hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = s;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    r.waits = 0; r.lo_resp = 1'b0; r.lo_nz = 1'b0;
    @(negedge clk);
    while (!c_rdy && r.waits < 20) begin
      r.waits++;
      r.lo_resp = c_resp;
      if (c_rdata != 0) r.lo_nz = 1'b1;
      @(negedge clk);
    end
    r.rdata = c_rdata;
    r.resp  = c_resp;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[$];
    xres_t r;
    logic [31:0] a, wd;
    logic [2:0]  s;
    bit          wr, e;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout", 32'(rdy_v[0]), 32'd1);
    chk("rst_hresp", 32'(resp_v[0]), 32'd0);
    chk("rst_hrdata", rd_v[0], 32'd0);
    chk("rst_hreadyout_ws3", 32'(rdy_v[1]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      xfer(0, 1'b1, 32'(i * 4), 3'd2, 32'h1357_0000 | 32'(i), r);
      model_write(32'(i * 4), 3'd2, 32'h1357_0000 | 32'(i));
    end

    tbl.push_back('{1'b1, 32'h040, 3'd2, 32'h0BADCAFE, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h040, 3'd2, 32'h0,        1'b0, 32'h0BADCAFE});
    tbl.push_back('{1'b1, 32'h041, 3'd0, 32'h00007700, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h040, 3'd2, 32'h0,        1'b0, 32'h0BAD77FE});
    tbl.push_back('{1'b1, 32'h040, 3'd1, 32'hFFFF1234, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h040, 3'd2, 32'h0,        1'b0, 32'h0BAD1234});
    tbl.push_back('{1'b1, 32'h043, 3'd0, 32'hEE111111, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h042, 3'd0, 32'h0,        1'b0, 32'hEEAD1234});
    tbl.push_back('{1'b0, 32'h400, 3'd2, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, 32'h002, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h008, 3'd3, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, 32'h041, 3'd1, 32'hFFFFFFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h040, 3'd2, 32'h0,        1'b0, 32'hEEAD1234});
    tbl.push_back('{1'b1, 32'h3FC, 3'd2, 32'h55AA55AA, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h3FD, 3'd0, 32'h0,        1'b0, 32'h55AA55AA});
    tbl.push_back('{1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 32'h000, 3'd3, 32'hFFFFFFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h000, 3'd2, 32'h0,        1'b0, 32'h13570000});
    tbl.push_back('{1'b0, 32'h008, 3'd2, 32'h0,        1'b0, 32'h13570002});

    foreach (tbl[i]) begin
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wd, r);
      chk($sformatf("vec%0d_hresp", i), 32'(r.resp), 32'(tbl[i].eresp));
      chk($sformatf("vec%0d_hrdata", i), r.rdata, tbl[i].erd);
      chk($sformatf("vec%0d_waits", i), 32'(r.waits), tbl[i].eresp ? 32'd1 : 32'd0);
      if (tbl[i].eresp) chk($sformatf("vec%0d_err1_hresp", i), 32'(r.lo_resp), 32'd1);
      if (tbl[i].wr && !tbl[i].eresp) model_write(tbl[i].addr, tbl[i].size, tbl[i].wd);
    end

    // back-to-back write then read of the same word, zero wait
    cur = 2'd0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    @(negedge clk);
    chk("b2b_ready_c0", 32'(c_rdy), 32'd1);
    @(posedge clk); #1;
    hwrite = 1'b0; hwdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("b2b_ready_c1", 32'(c_rdy), 32'd1);
    chk("b2b_wr_hrdata", c_rdata, 32'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = '0;
    @(negedge clk);
    chk("b2b_ready_c2", 32'(c_rdy), 32'd1);
    chk("b2b_rdata", c_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    model_write(32'h10, 3'd2, 32'hDEADBEEF);

    // sub-word halfword merge
    xfer(0, 1'b1, 32'h20, 3'd2, 32'h11223344, r);
    xfer(0, 1'b1, 32'h22, 3'd1, 32'hA5A55A5A, r);
    xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, r);
    chk("half_merge", r.rdata, 32'hA5A53344);
    model_write(32'h20, 3'd2, 32'hA5A53344);

    // BUSY / IDLE inside a burst, then an unselected NONSEQ
    cur = 2'd0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b01; haddr = 32'h34; hwdata = 32'h600DF00D;
    @(negedge clk);
    chk("busy_ready", 32'(c_rdy), 32'd1);
    chk("busy_resp", 32'(c_resp), 32'd0);
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("idle_ready", 32'(c_rdy), 32'd1);
    chk("idle_resp", 32'(c_resp), 32'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b10;
    @(negedge clk);
    chk("unsel_ready", 32'(c_rdy), 32'd1);
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk);
    chk("unsel_ready_dp", 32'(c_rdy), 32'd1);
    chk("unsel_resp_dp", 32'(c_resp), 32'd0);
    @(posedge clk); #1;
    model_write(32'h30, 3'd2, 32'h600DF00D);
    xfer(0, 1'b0, 32'h30, 3'd2, 32'h0, r);
    chk("burst_word30", r.rdata, model_word(32'h30));
    xfer(0, 1'b0, 32'h34, 3'd2, 32'h0, r);
    chk("burst_word34", r.rdata, model_word(32'h34));

    // wait-state timing, WAIT_STATES=3
    xfer(1, 1'b1, 32'h04, 3'd2, 32'h7E57DA7A, r);
    chk("ws3_wr_waits", 32'(r.waits), 32'd3);
    xfer(1, 1'b0, 32'h04, 3'd2, 32'h0, r);
    chk("ws3_rd_waits", 32'(r.waits), 32'd3);
    chk("ws3_rd_resp", 32'(r.resp), 32'd0);
    chk("ws3_lo_resp", 32'(r.lo_resp), 32'd0);
    chk("ws3_lo_hrdata", 32'(r.lo_nz), 32'd0);
    chk("ws3_rdata", r.rdata, 32'h7E57DA7A);

    // read-only slave: write errors, read is OKAY
    xfer(3, 1'b1, 32'h00, 3'd2, 32'h12345678, r);
    chk("ro_wr_waits", 32'(r.waits), 32'd1);
    chk("ro_err1_resp", 32'(r.lo_resp), 32'd1);
    chk("ro_err2_resp", 32'(r.resp), 32'd1);
    chk("ro_hrdata", r.rdata, 32'd0);
    xfer(3, 1'b0, 32'h00, 3'd2, 32'h0, r);
    chk("ro_rd_resp", 32'(r.resp), 32'd0);
    chk("ro_rd_waits", 32'(r.waits), 32'd0);

    // reset during wait cycle 2 of a write, WAIT_STATES=5
    xfer(2, 1'b1, 32'h08, 3'd2, 32'hCAFEF00D, r);
    chk("ws5_wr_waits", 32'(r.waits), 32'd5);
    cur = 2'd2; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h08; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
    @(negedge clk);
    chk("ws5_wait1_ready", 32'(c_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ws5_wait2_ready", 32'(c_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ws5_post_rst_ready", 32'(c_rdy), 32'd1);
    chk("ws5_post_rst_resp", 32'(c_resp), 32'd0);
    @(posedge clk); #1;
    hwdata = '0;
    xfer(2, 1'b0, 32'h08, 3'd2, 32'h0, r);
    chk("ws5_word_unchanged", r.rdata, 32'hCAFEF00D);
    chk("ws5_rd_waits", 32'(r.waits), 32'd5);

    // randomized traffic against the byte model (memory survived the reset)
    for (int i = 0; i < 300; i++) begin
      int sel;
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      s   = (sel == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (sel == 1)      a = 32'h400 + 32'($urandom_range(0, 255));
      else if (sel == 2) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      else               a = 32'($urandom_range(0, 255));
      if (s <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 1);
      wd = $urandom;
      e  = model_err(a, s, wr, 1'b0);
      xfer(0, wr, a, s, wd, r);
      chk($sformatf("rnd%0d_resp", i), 32'(r.resp), 32'(e));
      chk($sformatf("rnd%0d_waits", i), 32'(r.waits), e ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d_rdata", i), r.rdata, (e || wr) ? 32'd0 : model_word(a));
      if (wr && !e) model_write(a, s, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
